regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised integer register file with a per-register busy scoreboard and optional writeback bypass, the successor to the single-write, two-read RV32I register file. It sits between decode/issue and writeback in the core: issue marks destination registers pending, writeback commits data and clears the pending mark, and the read ports report operand readiness so issue can stall on RAW and WAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, at least 2. AW = clog2(NREGS) is derived, not a parameter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1  in  AW  read port 1 address.
- rs2  in  AW  read port 2 address.
- rdata1  out  XLEN  read port 1 data (combinational).
- rdata2  out  XLEN  read port 2 data (combinational).
- rs1_ready  out  1  operand 1 has no pending write, or is being bypassed.
- rs2_ready  out  1  operand 2 has no pending write, or is being bypassed.
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_stall  out  1  WAW hazard; the issue is not accepted.
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- busy_vec  out  NREGS  registered scoreboard bits; bit 0 is always 0.
- idle  out  1  high when busy_vec is all zeros.

## Operation
- Reset (rst_n low, async): all registers are set to 0 and busy_vec to 0. While in reset, idle = 1 and issue_stall = 0.
- Reads:
  - rdataN = regs[rsN]; rsN = 0 always returns 0.
  - rsN_ready = !busy[rsN], with the bypass term below added under REGFILE_BYPASS_EN.
- Writeback: when wb_valid and wb_rd != 0, regs[wb_rd] <= wb_data and busy[wb_rd] <= 0 at the clock edge. wb_rd = 0 is discarded.
- issue_stall = issue_valid && issue_rd != 0 && busy[issue_rd] && !(wb_valid && wb_rd == issue_rd).
- Issue: when issue_valid, issue_rd != 0 and !issue_stall, busy[issue_rd] <= 1 at the edge. A stalled issue has no state effect; upstream holds and retries.
- Simultaneous issue and writeback to the same rd:
  - Data is written.
  - busy ends at 1, because the new instruction owns the register.
  - issue_stall is 0.
- Simultaneous issue and writeback to different registers: both take effect independently.
- Writeback to a register that is not busy: data is written and busy stays 0. This is legal and used for untracked writes.
- idle = ~|busy_vec, computed from registered state.

## Timing
- Read ports: zero-cycle combinational from rsN and registered state (plus wb_* when bypass is enabled).
- Write and scoreboard updates become visible on the cycle after the edge.
- issue_stall is combinational from issue_* and wb_* within the same cycle.
- No other outputs have combinational paths from inputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wb_valid && wb_rd == rsN && rsN != 0, rdataN = wb_data and rsN_ready = 1 in the same cycle.
  - This makes writeback-to-read latency 0 cycles.
- REGFILE_BYPASS_EN undefined:
  - rdataN always reflects the stored register and rsN_ready reflects only busy.
  - A consumer sees writeback data 1 cycle after wb_valid.
  - The wb_* to rdata/ready combinational paths are absent.

## Test plan
- Reset then read: assert rst_n = 0 mid-run after writes. Required: all rdata = 0, busy_vec = 0, idle = 1, asynchronously and without waiting for a clock edge.
- x0 protection: wb_valid with wb_rd = 0 and wb_data = 0xDEADBEEF, plus issue_rd = 0. Required: rs1 = 0 reads 0, busy_vec[0] = 0, issue_stall = 0.
- RAW scoreboard: issue rd = 5; next cycle rs1 = 5. Required: rs1_ready = 0 and busy_vec = 0x20. Then wb rd = 5 with data 0x12345678:
  - Bypass build: same cycle rdata1 = 0x12345678 and rs1_ready = 1.
  - Non-bypass build: rs1_ready = 1 and rdata1 = 0x12345678 one cycle later.
- WAW stall: x7 is busy; issue_rd = 7 with no writeback. Required: issue_stall = 1 and busy is unchanged. Then issue_rd = 7 and wb_rd = 7 in the same cycle. Required: issue_stall = 0, regs[7] updated, busy[7] stays 1.
- Parametric build at XLEN = 64, NREGS = 16: write 0xFFFF_0000_FFFF_0000 to x15, issue x1, x2, x15, then write back all three. Required: data reads back intact, idle goes 1→0→1, busy_vec is 0x8006 while all three are pending.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard.
// Issue marks a destination pending, writeback commits data and clears the mark,
// and the read ports report operand readiness for RAW/WAW stalling. x0 reads 0
// and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward writeback data and
// readiness to the read ports in the same cycle.
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [XLEN-1:0]  rdata1,
    output logic [XLEN-1:0]  rdata2,
    output logic             rs1_ready,
    output logic             rs2_ready,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_stall,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [NREGS-1:0] busy_vec,
    output logic             idle
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_en;
    logic             issue_en;

    assign wb_en = wb_valid && (wb_rd != '0);

    // WAW hazard, unless writeback frees the same register this cycle.
    always_comb begin
        issue_stall = issue_valid && (issue_rd != '0) && busy_q[issue_rd]
                      && !(wb_valid && (wb_rd == issue_rd));
        issue_en    = issue_valid && (issue_rd != '0) && !issue_stall;
    end

    // Scoreboard next state: writeback clears first so a same-rd issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Register storage; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Read ports, with optional same-cycle writeback forwarding.
    always_comb begin
        rdata1    = (rs1 == '0) ? '0 : regs_q[rs1];
        rdata2    = (rs2 == '0) ? '0 : regs_q[rs2];
        rs1_ready = !busy_q[rs1];
        rs2_ready = !busy_q[rs2];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && (wb_rd == rs1)) begin
            rdata1    = wb_data;
            rs1_ready = 1'b1;
        end
        if (wb_en && (wb_rd == rs2)) begin
            rdata2    = wb_data;
            rs2_ready = 1'b1;
        end
`endif
    end

    assign busy_vec = busy_q;
    assign idle     = ~|busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a 32x32 instance driven by
// directed and random stimulus against a behavioural model, and a 64-bit
// 16-entry instance for the parametric case.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;

    // Default instance (XLEN 32, NREGS 32).
    logic [4:0]  rs1, rs2, issue_rd, wb_rd;
    logic [31:0] rdata1, rdata2, wb_data, busy_vec;
    logic        rs1_ready, rs2_ready, issue_valid, issue_stall, wb_valid, idle;

    // Parametric instance (XLEN 64, NREGS 16).
    logic [3:0]  b_rs1, b_rs2, b_issue_rd, b_wb_rd;
    logic [63:0] b_rdata1, b_rdata2, b_wb_data;
    logic [15:0] b_busy_vec;
    logic        b_rs1_ready, b_rs2_ready, b_issue_valid, b_issue_stall, b_wb_valid, b_idle;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected values, pushed when stimulus is driven.
    logic [63:0] exp_q [$];
    string       tag_q [$];

    // Behavioural model of the default instance.
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    regfile_scoreboard u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1         (rs1),
        .rs2         (rs2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .rs1_ready   (rs1_ready),
        .rs2_ready   (rs2_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy_vec    (busy_vec),
        .idle        (idle)
    );

    regfile_scoreboard #(
        .XLEN  (64),
        .NREGS (16)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1         (b_rs1),
        .rs2         (b_rs2),
        .rdata1      (b_rdata1),
        .rdata2      (b_rdata2),
        .rs1_ready   (b_rs1_ready),
        .rs2_ready   (b_rs2_ready),
        .issue_valid (b_issue_valid),
        .issue_rd    (b_issue_rd),
        .issue_stall (b_issue_stall),
        .wb_valid    (b_wb_valid),
        .wb_rd       (b_wb_rd),
        .wb_data     (b_wb_data),
        .busy_vec    (b_busy_vec),
        .idle        (b_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry");
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    function automatic logic model_stall();
        return issue_valid && (issue_rd != 0) && m_busy[issue_rd]
               && !(wb_valid && (wb_rd == issue_rd));
    endfunction

    function automatic logic [31:0] model_rdata(input logic [4:0] rs);
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && (wb_rd == rs) && (rs != 0)) return wb_data;
`endif
        return (rs == 0) ? 32'h0 : m_regs[rs];
    endfunction

    function automatic logic model_ready(input logic [4:0] rs);
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && (wb_rd == rs) && (rs != 0)) return 1'b1;
`endif
        return !m_busy[rs];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        b_issue_valid = 0; b_issue_rd = 0; b_wb_valid = 0; b_wb_rd = 0; b_wb_data = 0;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic step();
        logic st;
        @(posedge clk);
        st = model_stall();
        if (wb_valid && (wb_rd != 0)) begin
            m_regs[wb_rd] = wb_data;
            m_busy[wb_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 0) && !st) m_busy[issue_rd] = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 0;
        rs1 = 0; rs2 = 0; b_rs1 = 0; b_rs2 = 0;
        clear_inputs();
        model_reset();
        #2;
        check("reset_rdata1", rdata1, 0);
        check("reset_busy", busy_vec, 0);
        check("reset_idle", idle, 1);
        check("reset_stall", issue_stall, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Untracked writes, then a pending issue, then async reset mid-run.
        wb_valid = 1; wb_rd = 3; wb_data = 32'hA5A5_5A5A;
        step();
        wb_rd = 10; wb_data = 32'h0000_1111;
        step();
        wb_valid = 0; issue_valid = 1; issue_rd = 4;
        rs1 = 3; rs2 = 10; #2;
        check("untracked_rd1", rdata1, 32'hA5A5_5A5A);
        check("untracked_rd2", rdata2, 32'h0000_1111);
        check("untracked_busy", busy_vec, 0);
        step();
        clear_inputs();
        check("issue4_busy", busy_vec, 32'h10);
        #2 rst_n = 0;
        #1;
        check("async_rst_rdata1", rdata1, 0);
        check("async_rst_rdata2", rdata2, 0);
        check("async_rst_busy", busy_vec, 0);
        check("async_rst_idle", idle, 1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;

        // x0 protection.
        wb_valid = 1; wb_rd = 0; wb_data = 32'hDEAD_BEEF;
        issue_valid = 1; issue_rd = 0; rs1 = 0; #2;
        check("x0_stall", issue_stall, 0);
        step();
        clear_inputs(); #2;
        check("x0_read", rdata1, 0);
        check("x0_busy", busy_vec, 0);
        check("x0_idle", idle, 1);

        // RAW on x5.
        issue_valid = 1; issue_rd = 5;
        step();
        clear_inputs(); rs1 = 5; #2;
        check("raw_ready0", rs1_ready, 0);
        check("raw_busy", busy_vec, 32'h20);
        check("raw_idle", idle, 0);
        wb_valid = 1; wb_rd = 5; wb_data = 32'h1234_5678; #2;
`ifdef REGFILE_BYPASS_EN
        check("raw_byp_data", rdata1, 32'h1234_5678);
        check("raw_byp_ready", rs1_ready, 1);
`else
        check("raw_nobyp_data", rdata1, 0);
        check("raw_nobyp_ready", rs1_ready, 0);
`endif
        step();
        clear_inputs(); #2;
        check("raw_after_data", rdata1, 32'h1234_5678);
        check("raw_after_ready", rs1_ready, 1);
        check("raw_after_busy", busy_vec, 0);

        // WAW on x7.
        issue_valid = 1; issue_rd = 7;
        step();
        #2;
        check("waw_stall", issue_stall, 1);
        step();
        check("waw_busy_held", busy_vec, 32'h80);
        wb_valid = 1; wb_rd = 7; wb_data = 32'h0000_0077; #2;
        check("waw_wb_stall", issue_stall, 0);
        step();
        clear_inputs(); rs1 = 7; rs2 = 7; #2;
        check("waw_data", rdata1, 32'h77);
        check("waw_busy", busy_vec, 32'h80);
        check("waw_ready2", rs2_ready, 0);
        // Issue and writeback to different registers in one cycle.
        issue_valid = 1; issue_rd = 8; wb_valid = 1; wb_rd = 7; wb_data = 32'hCAFE_0007;
        step();
        clear_inputs(); #2;
        check("diff_busy", busy_vec, 32'h100);
        check("diff_data", rdata1, 32'hCAFE_0007);
        wb_valid = 1; wb_rd = 8; wb_data = 32'h8;
        step();
        clear_inputs();

        // Random traffic checked against the model through the scoreboard queue.
        for (int n = 0; n < 400; n++) begin
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd = 5'($urandom_range(0, 31));
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_rd = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            push_exp("rnd_rdata1", 64'(model_rdata(rs1)));
            push_exp("rnd_rdata2", 64'(model_rdata(rs2)));
            push_exp("rnd_ready1", 64'(model_ready(rs1)));
            push_exp("rnd_ready2", 64'(model_ready(rs2)));
            push_exp("rnd_stall", 64'(model_stall()));
            push_exp("rnd_busy", 64'(m_busy));
            push_exp("rnd_idle", 64'(m_busy == 0));
            #2;
            pop_check(64'(rdata1));
            pop_check(64'(rdata2));
            pop_check(64'(rs1_ready));
            pop_check(64'(rs2_ready));
            pop_check(64'(issue_stall));
            pop_check(64'(busy_vec));
            pop_check(64'(idle));
            step();
        end
        clear_inputs();

        // Parametric instance: 64-bit data, 16 registers.
        b_wb_valid = 1; b_wb_rd = 15; b_wb_data = 64'hFFFF_0000_FFFF_0000;
        step();
        clear_inputs(); b_rs1 = 15;
        push_exp("b_x15_init", 64'hFFFF_0000_FFFF_0000);
        #2;
        pop_check(b_rdata1);
        check("b_idle_start", 64'(b_idle), 1);
        b_issue_valid = 1; b_issue_rd = 1;
        step();
        b_issue_rd = 2;
        step();
        b_issue_rd = 15;
        step();
        clear_inputs(); #2;
        check("b_busy_pending", 64'(b_busy_vec), 64'h8006);
        check("b_idle_pending", 64'(b_idle), 0);
        b_wb_valid = 1; b_wb_rd = 1; b_wb_data = 64'hFFFF_FFFF_0000_0001;
        step();
        b_wb_rd = 2; b_wb_data = 64'h8000_0000_0000_0002;
        step();
        b_wb_rd = 15; b_wb_data = 64'hFFFF_0000_FFFF_0000;
        step();
        clear_inputs(); b_rs1 = 1; b_rs2 = 2;
        push_exp("b_x1", 64'hFFFF_FFFF_0000_0001);
        push_exp("b_x2", 64'h8000_0000_0000_0002);
        #2;
        pop_check(b_rdata1);
        pop_check(b_rdata2);
        b_rs1 = 15;
        push_exp("b_x15", 64'hFFFF_0000_FFFF_0000);
        #1;
        pop_check(b_rdata1);
        check("b_busy_end", 64'(b_busy_vec), 0);
        check("b_idle_end", 64'(b_idle), 1);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
